// File: rtl/div_result_stage_if.sv
// Handshake bundle between the divider, the result stage and the HI/LO writeback.
// The master drives divider results and writeback ready; the slave is the stage itself.
interface div_result_stage_if #(
   parameter int WIDTH = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [2*WIDTH-1:0] z_in;
   logic               dividend_neg;
   logic               divisor_neg;
   logic               divisor_zero;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   hi_out;
   logic [WIDTH-1:0]   lo_out;
   logic               dz_flag;
   logic               dz_sticky;
   logic               sticky_clr;
   logic [15:0]        op_count;

   modport master (
      output in_valid, z_in, dividend_neg, divisor_neg, divisor_zero,
      output out_ready, sticky_clr,
      input  in_ready, out_valid, hi_out, lo_out, dz_flag, dz_sticky, op_count
   );

   modport slave (
      input  in_valid, z_in, dividend_neg, divisor_neg, divisor_zero,
      input  out_ready, sticky_clr,
      output in_ready, out_valid, hi_out, lo_out, dz_flag, dz_sticky, op_count
   );
endinterface

// File: rtl/div_result_stage.sv
// Two-entry registered stage after the unsigned divider: applies sign correction,
// forces the quotient on divide-by-zero, and hands signed HI/LO to writeback.
module div_result_stage #(
   parameter int WIDTH = 32
) (
   input  logic                clock,
   input  logic                clear,
   div_result_stage_if.slave   bus
);

   // Two's complement negation when neg is set; wraps silently mod 2^WIDTH.
   function automatic logic [WIDTH-1:0] cond_negate(
      input logic [WIDTH-1:0] value,
      input logic             neg
   );
      logic [WIDTH-1:0] result;
      if (neg) begin
         result = (~value) + {{(WIDTH-1){1'b0}}, 1'b1};
      end else begin
         result = value;
      end
      return result;
   endfunction

   // Stage 1 holding register (raw magnitudes plus operand flags)
   logic               s1_valid_r;
   logic [2*WIDTH-1:0] s1_z_r;
   logic               s1_dividend_neg_r;
   logic               s1_divisor_neg_r;
   logic               s1_divisor_zero_r;

   // Stage 2 output register
   logic               out_valid_r;
   logic [WIDTH-1:0]   hi_r;
   logic [WIDTH-1:0]   lo_r;
   logic               dz_flag_r;
   logic               dz_sticky_r;
   logic [15:0]        op_count_r;

   logic               in_ready_s;
   logic               s1_load_s;
   logic               s2_load_s;
   logic               s2_drain_s;
   logic [WIDTH-1:0]   hi_corr_s;
   logic [WIDTH-1:0]   lo_corr_s;

   // Handshake decode; in_ready must not depend on in_valid.
   always_comb begin
      in_ready_s = 1'b1;
      s2_drain_s = 1'b0;
      s2_load_s  = 1'b0;
      s1_load_s  = 1'b0;
      in_ready_s = (!s1_valid_r) || (!out_valid_r) || bus.out_ready;
      s2_drain_s = out_valid_r && bus.out_ready;
      s2_load_s  = s1_valid_r && ((!out_valid_r) || bus.out_ready);
      s1_load_s  = bus.in_valid && in_ready_s;
   end

   // Sign correction on the S1 -> S2 path; a zero divisor forces the quotient to all ones.
   always_comb begin
      hi_corr_s = {WIDTH{1'b0}};
      lo_corr_s = {WIDTH{1'b0}};
      hi_corr_s = cond_negate(s1_z_r[2*WIDTH-1:WIDTH], s1_dividend_neg_r);
      if (s1_divisor_zero_r) begin
         lo_corr_s = {WIDTH{1'b1}};
      end else begin
         lo_corr_s = cond_negate(s1_z_r[WIDTH-1:0],
                                 s1_dividend_neg_r ^ s1_divisor_neg_r);
      end
   end

   // Stage 1 capture; a load wins over a same-edge hand-off to S2.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         s1_valid_r        <= 1'b0;
         s1_z_r            <= {(2*WIDTH){1'b0}};
         s1_dividend_neg_r <= 1'b0;
         s1_divisor_neg_r  <= 1'b0;
         s1_divisor_zero_r <= 1'b0;
      end else begin
         if (s1_load_s) begin
            s1_valid_r        <= 1'b1;
            s1_z_r            <= bus.z_in;
            s1_dividend_neg_r <= bus.dividend_neg;
            s1_divisor_neg_r  <= bus.divisor_neg;
            s1_divisor_zero_r <= bus.divisor_zero;
         end else if (s2_load_s) begin
            s1_valid_r <= 1'b0;
         end else begin
            s1_valid_r <= s1_valid_r;
         end
      end
   end

   // Stage 2 output register; holds while the consumer stalls.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         out_valid_r <= 1'b0;
         hi_r        <= {WIDTH{1'b0}};
         lo_r        <= {WIDTH{1'b0}};
         dz_flag_r   <= 1'b0;
      end else begin
         if (s2_load_s) begin
            out_valid_r <= 1'b1;
            hi_r        <= hi_corr_s;
            lo_r        <= lo_corr_s;
            dz_flag_r   <= s1_divisor_zero_r;
         end else if (s2_drain_s) begin
            out_valid_r <= 1'b0;
         end else begin
            out_valid_r <= out_valid_r;
         end
      end
   end

   // Sticky divide-by-zero: a dz load on the same edge as sticky_clr keeps it set.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         dz_sticky_r <= 1'b0;
      end else begin
         if (s2_load_s && s1_divisor_zero_r) begin
            dz_sticky_r <= 1'b1;
         end else if (bus.sticky_clr) begin
            dz_sticky_r <= 1'b0;
         end else begin
            dz_sticky_r <= dz_sticky_r;
         end
      end
   end

   // Delivered-result counter, free-running with wrap.
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         op_count_r <= 16'd0;
      end else begin
         if (s2_drain_s) begin
            op_count_r <= op_count_r + 16'd1;
         end else begin
            op_count_r <= op_count_r;
         end
      end
   end

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_r;
   assign bus.hi_out    = hi_r;
   assign bus.lo_out    = lo_r;
   assign bus.dz_flag   = dz_flag_r;
   assign bus.dz_sticky = dz_sticky_r;
   assign bus.op_count  = op_count_r;

endmodule

// File: tb/tb_div_result_stage.sv
// Directed bench for div_result_stage: sign correction, divide-by-zero,
// back-pressure ordering and asynchronous clear.
module tb_div_result_stage;
   localparam int WIDTH = 32;

   logic clock;
   logic clear;
   int   checks;
   int   errors;
   logic [15:0] exp_cnt;

   div_result_stage_if #(.WIDTH(WIDTH)) bus ();

   div_result_stage #(.WIDTH(WIDTH)) dut (
      .clock (clock),
      .clear (clear),
      .bus   (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One complete operation with out_ready held high: accept, latency, result, handshake.
   task automatic one_op(input string tag, input logic [31:0] r, input logic [31:0] q,
                         input logic dn, input logic vn, input logic dz,
                         input logic [31:0] eh, input logic [31:0] el, input logic edz);
      @(negedge clock);
      bus.in_valid     = 1'b1;
      bus.z_in         = {r, q};
      bus.dividend_neg = dn;
      bus.divisor_neg  = vn;
      bus.divisor_zero = dz;
      bus.out_ready    = 1'b1;
      @(posedge clock); #1;
      chk({tag, "_latency"}, {63'd0, bus.out_valid}, 64'd0);
      @(negedge clock);
      bus.in_valid     = 1'b0;
      bus.z_in         = 64'hA5A5_5A5A_C3C3_3C3C;
      bus.dividend_neg = 1'b0;
      bus.divisor_neg  = 1'b0;
      bus.divisor_zero = 1'b0;
      @(posedge clock); #1;
      chk({tag, "_valid"}, {63'd0, bus.out_valid}, 64'd1);
      chk({tag, "_hi"}, {32'd0, bus.hi_out}, {32'd0, eh});
      chk({tag, "_lo"}, {32'd0, bus.lo_out}, {32'd0, el});
      chk({tag, "_dz"}, {63'd0, bus.dz_flag}, {63'd0, edz});
      @(posedge clock); #1;
      exp_cnt = exp_cnt + 16'd1;
      chk({tag, "_drained"}, {63'd0, bus.out_valid}, 64'd0);
      chk({tag, "_count"}, {48'd0, bus.op_count}, {48'd0, exp_cnt});
   endtask

   initial begin
      checks           = 0;
      errors           = 0;
      exp_cnt          = 16'd0;
      clear            = 1'b1;
      bus.in_valid     = 1'b0;
      bus.z_in         = 64'd0;
      bus.dividend_neg = 1'b0;
      bus.divisor_neg  = 1'b0;
      bus.divisor_zero = 1'b0;
      bus.out_ready    = 1'b1;
      bus.sticky_clr   = 1'b0;

      // Reset state
      repeat (2) @(posedge clock);
      #1;
      chk("rst_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("rst_hi", {32'd0, bus.hi_out}, 64'd0);
      chk("rst_lo", {32'd0, bus.lo_out}, 64'd0);
      chk("rst_dz", {63'd0, bus.dz_flag}, 64'd0);
      chk("rst_sticky", {63'd0, bus.dz_sticky}, 64'd0);
      chk("rst_count", {48'd0, bus.op_count}, 64'd0);
      @(negedge clock);
      clear = 1'b0;
      #1;
      chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);

      // Sign combinations on 7/2 magnitudes
      one_op("pos",   32'd1, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0003, 1'b0);
      one_op("dvdneg", 32'd1, 32'd3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      one_op("dvsneg", 32'd1, 32'd3, 1'b0, 1'b1, 1'b0, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0);
      one_op("bothneg", 32'd1, 32'd3, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0);

      // Overflow wrap passes through silently
      one_op("wrap", 32'd0, 32'h8000_0000, 1'b1, 1'b1, 1'b0, 32'h0000_0000, 32'h8000_0000, 1'b0);

      // Divide-by-zero and sticky behaviour
      one_op("dz", 32'd9, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 32'h0000_0009, 32'hFFFF_FFFF, 1'b1);
      chk("dz_sticky_set", {63'd0, bus.dz_sticky}, 64'd1);
      one_op("after_dz", 32'd1, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0003, 1'b0);
      chk("dz_sticky_hold", {63'd0, bus.dz_sticky}, 64'd1);

      @(negedge clock);
      bus.in_valid     = 1'b1;
      bus.z_in         = {32'd5, 32'h0000_0000};
      bus.dividend_neg = 1'b1;
      bus.divisor_zero = 1'b1;
      @(negedge clock);
      bus.in_valid     = 1'b0;
      bus.dividend_neg = 1'b0;
      bus.divisor_zero = 1'b0;
      bus.sticky_clr   = 1'b1;
      @(posedge clock); #1;
      chk("clr_vs_set_sticky", {63'd0, bus.dz_sticky}, 64'd1);
      chk("clr_vs_set_hi", {32'd0, bus.hi_out}, 64'h0000_0000_FFFF_FFFB);
      chk("clr_vs_set_lo", {32'd0, bus.lo_out}, 64'h0000_0000_FFFF_FFFF);
      @(negedge clock);
      bus.sticky_clr = 1'b0;
      @(posedge clock); #1;
      exp_cnt = exp_cnt + 16'd1;
      chk("clr_vs_set_count", {48'd0, bus.op_count}, {48'd0, exp_cnt});
      @(negedge clock);
      bus.sticky_clr = 1'b1;
      @(posedge clock); #1;
      chk("plain_clr_sticky", {63'd0, bus.dz_sticky}, 64'd0);
      @(negedge clock);
      bus.sticky_clr = 1'b0;

      // Back-pressure: A and B buffer, C waits, then all drain in order
      bus.out_ready = 1'b0;
      bus.in_valid  = 1'b1;
      bus.z_in      = {32'd1, 32'h0000_0011};
      @(posedge clock); #1;
      chk("bp_ready_after_a", {63'd0, bus.in_ready}, 64'd1);
      @(negedge clock);
      bus.z_in = {32'd2, 32'h0000_0022};
      @(posedge clock); #1;
      chk("bp_ready_after_b", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_head_a", {32'd0, bus.lo_out}, 64'h11);
      @(negedge clock);
      bus.z_in = {32'd3, 32'h0000_0033};
      @(posedge clock); #1;
      chk("bp_still_full", {63'd0, bus.in_ready}, 64'd0);
      chk("bp_hold_lo", {32'd0, bus.lo_out}, 64'h11);
      chk("bp_hold_hi", {32'd0, bus.hi_out}, 64'h1);
      chk("bp_hold_count", {48'd0, bus.op_count}, {48'd0, exp_cnt});
      @(negedge clock);
      bus.out_ready = 1'b1;
      #1;
      chk("bp_ready_released", {63'd0, bus.in_ready}, 64'd1);
      @(posedge clock); #1;
      exp_cnt = exp_cnt + 16'd1;
      chk("bp_second_b", {32'd0, bus.lo_out}, 64'h22);
      chk("bp_count_a", {48'd0, bus.op_count}, {48'd0, exp_cnt});
      @(negedge clock);
      bus.in_valid = 1'b0;
      @(posedge clock); #1;
      exp_cnt = exp_cnt + 16'd1;
      chk("bp_third_c", {32'd0, bus.lo_out}, 64'h33);
      chk("bp_third_c_hi", {32'd0, bus.hi_out}, 64'h3);
      chk("bp_third_valid", {63'd0, bus.out_valid}, 64'd1);
      @(posedge clock); #1;
      exp_cnt = exp_cnt + 16'd1;
      chk("bp_empty", {63'd0, bus.out_valid}, 64'd0);
      chk("bp_count_all", {48'd0, bus.op_count}, {48'd0, exp_cnt});

      // Asynchronous clear with two results buffered
      @(negedge clock);
      bus.out_ready    = 1'b0;
      bus.in_valid     = 1'b1;
      bus.z_in         = {32'd4, 32'h0000_0044};
      bus.divisor_zero = 1'b1;
      @(negedge clock);
      bus.divisor_zero = 1'b0;
      bus.z_in         = {32'd5, 32'h0000_0055};
      @(negedge clock);
      bus.in_valid = 1'b0;
      #1;
      chk("pre_clr_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("pre_clr_sticky", {63'd0, bus.dz_sticky}, 64'd1);
      #1;
      clear = 1'b1;
      #1;
      chk("aclr_valid", {63'd0, bus.out_valid}, 64'd0);
      chk("aclr_hi", {32'd0, bus.hi_out}, 64'd0);
      chk("aclr_lo", {32'd0, bus.lo_out}, 64'd0);
      chk("aclr_count", {48'd0, bus.op_count}, 64'd0);
      chk("aclr_sticky", {63'd0, bus.dz_sticky}, 64'd0);
      @(negedge clock);
      clear         = 1'b0;
      bus.out_ready = 1'b1;
      exp_cnt       = 16'd0;
      #1;
      chk("post_clr_ready", {63'd0, bus.in_ready}, 64'd1);
      one_op("fresh", 32'd1, 32'd3, 1'b0, 1'b0, 1'b0, 32'h0000_0001, 32'h0000_0003, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global time limit so the run always ends.
   initial begin
      #20000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "time limit reached");
   end

endmodule
